// File: rtl/dot_result_drain_if.sv
// Handshake bundle linking the drain stage to its controller, the accumulator bank and the write sink.
interface dot_result_drain_if #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int CountWidth = $clog2(PE_COUNT) + 1;

  logic                                 start;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  dot_in;
  logic [ADDR_WIDTH-1:0]                base_addr;
  logic [CountWidth-1:0]                count;
  logic                                 wr_valid;
  logic                                 wr_ready;
  logic [ADDR_WIDTH-1:0]                wr_addr;
  logic [DATA_WIDTH-1:0]                wr_data;
  logic                                 busy;
  logic                                 done;

  modport master (
    output start, dot_in, base_addr, count, wr_ready,
    input  wr_valid, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, dot_in, base_addr, count, wr_ready,
    output wr_valid, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/dot_result_drain.sv
// Snapshots the accumulator result vector and streams the selected lanes out over a valid/ready write port.
// Optional macro DOT_DRAIN_RELU_EN clamps negative lanes to zero as they are captured.
module dot_result_drain #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic                clk,
  input logic                rstn,
  dot_result_drain_if.slave  bus
);
  localparam int CW = $clog2(PE_COUNT) + 1;
  localparam int IW = $clog2(PE_COUNT);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e                               state_q, state_d;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  snap_q, snap_d;
  logic [ADDR_WIDTH-1:0]                base_q, base_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [CW-1:0]                        lane_q, lane_d;
  logic                                 wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0]                wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]                wr_data_q, wr_data_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  function automatic logic [DATA_WIDTH-1:0] capture(input logic [DATA_WIDTH-1:0] v);
`ifdef DOT_DRAIN_RELU_EN
    capture = v[DATA_WIDTH-1] ? '0 : v;
`else
    capture = v;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs are registered from the next-state values, so lane 0 appears the cycle after start.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < PE_COUNT; i++) begin
            snap_d[i] = capture(bus.dot_in[i]);
          end
          base_d  = bus.base_addr;
          cnt_d   = (bus.count > CW'(PE_COUNT)) ? CW'(PE_COUNT) : bus.count;
          lane_d  = '0;
          state_d = (cnt_d == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (wr_valid_q && bus.wr_ready) begin
          lane_d = lane_q + CW'(1);
          if (lane_q == cnt_q - CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_valid_d = (state_d == DRAIN);
    wr_addr_d  = wr_valid_d ? base_d + ADDR_WIDTH'(lane_d) : '0;
    wr_data_d  = wr_valid_d ? snap_d[lane_d[IW-1:0]] : '0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_dot_result_drain.sv
// Directed and randomized drains scored against a queue-based model of the expected write sequence.
module tb_dot_result_drain;
  localparam int PE = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = $clog2(PE) + 1;

  typedef logic [PE-1:0][DW-1:0] vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   numCompared   = 0;
  int   numMismatched = 0;

  dot_result_drain_if #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dif();

  dot_result_drain #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numCompared++;
    assert (observed === expected) else begin
      numMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] reluModel(input logic [DW-1:0] v);
`ifdef DOT_DRAIN_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"}, 64'(dif.busy), 64'(0));
    checkOutput({tag, ".done"}, 64'(dif.done), 64'(0));
    checkOutput({tag, ".wr_valid"}, 64'(dif.wr_valid), 64'(0));
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle again.
  // readyMode: 0 = always ready, 1 = random ready, 2 = ready low for 3 cycles on lane 1.
  task automatic applyStimulus(input vec_t vec, input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                               input int readyMode, input bit scramble, input bit poke);
    logic [AW-1:0] addrQ[$];
    logic [DW-1:0] dataQ[$];
    int  n;
    int  lane      = 0;
    int  stallLeft = 3;
    int  stalls    = 0;
    bit  r;
    n = (int'(cnt) > PE) ? PE : int'(cnt);
    for (int i = 0; i < n; i++) begin
      addrQ.push_back(AW'(int'(base) + i));
      dataQ.push_back(reluModel(vec[i]));
    end
    dif.start     = 1'b1;
    dif.dot_in    = vec;
    dif.base_addr = base;
    dif.count     = cnt;
    dif.wr_ready  = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        dif.start = 1'b0;
        if (scramble) begin
          dif.dot_in    = '1;
          dif.base_addr = AW'($urandom);
          dif.count     = CW'($urandom);
        end
      end
      checkOutput("busy", 64'(dif.busy), 64'(1));
      checkOutput("wr_valid", 64'(dif.wr_valid), 64'(addrQ.size() != 0));
      checkOutput("done", 64'(dif.done), 64'(addrQ.size() == 0));
      if (addrQ.size() == 0) begin
        checkOutput("latency", 64'(cyc), 64'(n + 1 + stalls));
        dif.start    = 1'b0;
        dif.wr_ready = 1'($urandom_range(0, 1));
        break;
      end
      checkOutput("wr_addr", 64'(dif.wr_addr), 64'(addrQ[0]));
      checkOutput("wr_data", 64'(dif.wr_data), 64'(dataQ[0]));
      case (readyMode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = !(lane == 1 && stallLeft > 0);
      endcase
      if (!r && readyMode == 2) stallLeft--;
      dif.wr_ready = r;
      if (r) begin
        void'(addrQ.pop_front());
        void'(dataQ.pop_front());
        lane++;
      end else begin
        stalls++;
      end
      if (poke) dif.start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checkIdle("afterDone");
  endtask

  initial begin
    vec_t basicVec;
    vec_t reluVec;
    vec_t rndVec;

    basicVec[0] = 32'h10; basicVec[1] = 32'h20; basicVec[2] = 32'h30; basicVec[3] = 32'h40;
    reluVec[0]  = 32'hFFFF_FFFF; reluVec[1] = 32'h5; reluVec[2] = 32'h8000_0000; reluVec[3] = 32'h7FFF_FFFF;

    dif.start     = 1'b0;
    dif.dot_in    = '0;
    dif.base_addr = '0;
    dif.count     = '0;
    dif.wr_ready  = 1'b1;

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset.wr_addr", 64'(dif.wr_addr), 64'(0));
    checkOutput("reset.wr_data", 64'(dif.wr_data), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    checkIdle("postReset");

    $display("[TB] basic drain, back-to-back backpressure drain");
    applyStimulus(basicVec, 8'h10, 3'd4, 0, 1'b0, 1'b0);
    applyStimulus(basicVec, 8'h10, 3'd4, 2, 1'b0, 1'b0);

    $display("[TB] wrap with clamp, zero count");
    applyStimulus(basicVec, 8'hFE, 3'd7, 0, 1'b0, 1'b0);
    applyStimulus(basicVec, 8'h22, 3'd0, 0, 1'b0, 1'b0);

    $display("[TB] snapshot isolation with ignored start");
    applyStimulus(basicVec, 8'h40, 3'd4, 1, 1'b1, 1'b1);

    $display("[TB] lane sign handling");
    applyStimulus(reluVec, 8'h80, 3'd4, 0, 1'b0, 1'b0);

    $display("[TB] reset mid-drain");
    dif.start = 1'b1; dif.dot_in = basicVec; dif.base_addr = 8'h10; dif.count = 3'd4; dif.wr_ready = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    checkOutput("rst.lane0.addr", 64'(dif.wr_addr), 64'(8'h10));
    @(negedge clk);
    checkOutput("rst.lane1.data", 64'(dif.wr_data), 64'(32'h20));
    @(negedge clk);
    checkOutput("rst.lane2.addr", 64'(dif.wr_addr), 64'(8'h12));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkIdle("rst.out");
    checkOutput("rst.wr_addr", 64'(dif.wr_addr), 64'(0));
    checkOutput("rst.wr_data", 64'(dif.wr_data), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkIdle("rst.noDone");
    end
    applyStimulus(basicVec, 8'h10, 3'd4, 0, 1'b0, 1'b0);

    $display("[TB] randomized drains");
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < PE; i++) rndVec[i] = $urandom;
      applyStimulus(rndVec, AW'($urandom), CW'($urandom_range(0, 7)), 1,
                    1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        checkIdle("gap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end
endmodule
